// File: rtl/mtimer_irq.sv
// mtimer_irq: memory-mapped 64-bit machine timer (mtime/mtimecmp, prescaler, level IRQ).
// Define MTIMER_AUTO_RELOAD_EN to add RELOAD_LO/HI and periodic mtimecmp advance.
module mtimer_irq #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_wr_en,
  input  logic        i_rd_en,
  output logic [31:0] o_rdata,
  output logic        o_hit,
  output logic        o_tm_interupt
);

  localparam logic [2:0] OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_PRESCALE = 3'd5;
  localparam logic [2:0] OFF_RELOAD_LO = 3'd6;
  localparam logic [2:0] OFF_RELOAD_HI = 3'd7;

  logic [63:0]        r_mtime;
  logic [63:0]        r_mtimecmp;
  logic               r_en;
  logic               r_ie;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_pcnt;
  logic               r_irq;

  logic               w_wr;
  logic [2:0]         w_off;
  logic               w_tick;
  logic               w_match;
  logic               w_irq_cond;
  logic               w_cmp_wr;
  logic [31:0]        w_rdata;
  logic               w_unused_addr;

  assign o_hit         = (i_addr[31:5] == BASE_ADDR[31:5]);
  assign w_off         = i_addr[4:2];
  assign w_wr          = i_wr_en & o_hit;
  assign w_unused_addr = ^i_addr[1:0];

  // r_pcnt counts down the cycles left to the next tick; reloads from PRESCALE.
  assign w_tick     = r_en & (r_pcnt == '0);
  assign w_match    = (r_mtime >= r_mtimecmp);
  assign w_irq_cond = r_en & r_ie & w_match;
  assign w_cmp_wr   = w_wr & ((w_off == OFF_CMP_LO) | (w_off == OFF_CMP_HI));

`ifdef MTIMER_AUTO_RELOAD_EN
  logic [63:0] r_reload;
  logic        w_reload_fire;

  assign w_reload_fire = w_irq_cond & (r_reload != '0) & ~w_cmp_wr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_reload <= '0;
    end else if (w_wr && w_off == OFF_RELOAD_LO) begin
      r_reload[31:0] <= i_wdata;
    end else if (w_wr && w_off == OFF_RELOAD_HI) begin
      r_reload[63:32] <= i_wdata;
    end
  end
`endif

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_MTIME_LO:  w_rdata = r_mtime[31:0];
      OFF_MTIME_HI:  w_rdata = r_mtime[63:32];
      OFF_CMP_LO:    w_rdata = r_mtimecmp[31:0];
      OFF_CMP_HI:    w_rdata = r_mtimecmp[63:32];
      OFF_CTRL:      w_rdata = {30'd0, r_ie, r_en};
      OFF_PRESCALE:  w_rdata = 32'(r_presc);
`ifdef MTIMER_AUTO_RELOAD_EN
      OFF_RELOAD_LO: w_rdata = r_reload[31:0];
      OFF_RELOAD_HI: w_rdata = r_reload[63:32];
`endif
      default:       w_rdata = '0;
    endcase
    o_rdata = (i_rd_en && o_hit) ? w_rdata : 32'd0;
  end

  // A software write to either mtime half wins over the tick; no carry is generated.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mtime <= '0;
    end else if (w_wr && w_off == OFF_MTIME_LO) begin
      r_mtime[31:0] <= i_wdata;
    end else if (w_wr && w_off == OFF_MTIME_HI) begin
      r_mtime[63:32] <= i_wdata;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mtimecmp <= '1;
    end else if (w_wr && w_off == OFF_CMP_LO) begin
      r_mtimecmp[31:0] <= i_wdata;
    end else if (w_wr && w_off == OFF_CMP_HI) begin
      r_mtimecmp[63:32] <= i_wdata;
`ifdef MTIMER_AUTO_RELOAD_EN
    end else if (w_reload_fire) begin
      r_mtimecmp <= r_mtimecmp + r_reload;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en <= 1'b0;
      r_ie <= 1'b0;
    end else if (w_wr && w_off == OFF_CTRL) begin
      r_en <= i_wdata[0];
      r_ie <= i_wdata[1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_pcnt  <= '0;
    end else if (w_wr && w_off == OFF_PRESCALE) begin
      r_presc <= i_wdata[PRESC_W-1:0];
      r_pcnt  <= i_wdata[PRESC_W-1:0];
    end else if (w_tick) begin
      r_pcnt  <= r_presc;
    end else if (r_en) begin
      r_pcnt  <= r_pcnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_irq_cond;
    end
  end

  assign o_tm_interupt = r_irq;

endmodule

// File: tb/tb_mtimer_irq.sv
// Testbench for mtimer_irq: directed scenarios, then randomized bus traffic against a
// cycle-level reference model of the timer registers.
module tb_mtimer_irq;

  localparam logic [31:0] BASE = 32'h0000_2000;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_wr_en;
  logic        i_rd_en;
  logic [31:0] o_rdata;
  logic        o_hit;
  logic        o_tm_interupt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [63:0] m_mtime, m_cmp, m_reload;
  logic        m_en, m_ie, m_irq;
  logic [15:0] m_presc;
  int unsigned m_pc;

  mtimer_irq #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_wr_en(i_wr_en), .i_rd_en(i_rd_en), .o_rdata(o_rdata), .o_hit(o_hit),
    .o_tm_interupt(o_tm_interupt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] off);
    case (off)
      3'd0: return m_mtime[31:0];
      3'd1: return m_mtime[63:32];
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {30'd0, m_ie, m_en};
      3'd5: return {16'd0, m_presc};
`ifdef MTIMER_AUTO_RELOAD_EN
      3'd6: return m_reload[31:0];
      3'd7: return m_reload[63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock: model computes the next state from the inputs held across the edge.
  task automatic do_cycle();
    logic [63:0] n_mtime, n_cmp, n_reload;
    logic        n_en, n_ie, n_irq, wr, tick, match;
    logic [15:0] n_presc;
    int unsigned n_pc;
    logic [2:0]  off;
    if (i_rst) begin
      n_mtime = 64'd0; n_cmp = '1; n_reload = 64'd0;
      n_en = 1'b0; n_ie = 1'b0; n_irq = 1'b0; n_presc = 16'd0; n_pc = 0;
    end else begin
      wr    = i_wr_en && ((i_addr >> 5) == (BASE >> 5));
      off   = i_addr[4:2];
      tick  = m_en && (m_pc == 32'(m_presc));
      match = (m_mtime >= m_cmp);
      n_irq = m_en && m_ie && match;
      n_en = m_en; n_ie = m_ie; n_presc = m_presc; n_cmp = m_cmp; n_reload = m_reload;
      n_mtime = tick ? m_mtime + 64'd1 : m_mtime;
      n_pc    = !m_en ? m_pc : (tick ? 0 : m_pc + 1);
      if (wr) begin
        case (off)
          3'd0: n_mtime = {m_mtime[63:32], i_wdata};
          3'd1: n_mtime = {i_wdata, m_mtime[31:0]};
          3'd2: n_cmp   = {m_cmp[63:32], i_wdata};
          3'd3: n_cmp   = {i_wdata, m_cmp[31:0]};
          3'd4: begin n_en = i_wdata[0]; n_ie = i_wdata[1]; end
          3'd5: begin n_presc = i_wdata[15:0]; n_pc = 0; end
`ifdef MTIMER_AUTO_RELOAD_EN
          3'd6: n_reload = {m_reload[63:32], i_wdata};
          3'd7: n_reload = {i_wdata, m_reload[31:0]};
`endif
          default: ;
        endcase
      end
`ifdef MTIMER_AUTO_RELOAD_EN
      if (n_irq && m_reload != 64'd0 && !(wr && (off == 3'd2 || off == 3'd3)))
        n_cmp = m_cmp + m_reload;
`endif
    end
    @(posedge i_clk);
    m_mtime = n_mtime; m_cmp = n_cmp; m_reload = n_reload; m_en = n_en; m_ie = n_ie;
    m_irq = n_irq; m_presc = n_presc; m_pc = n_pc;
    #1;
    check("irq", {63'd0, o_tm_interupt}, {63'd0, m_irq});
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] data);
    i_addr = BASE + {27'd0, off, 2'b00}; i_wdata = data; i_wr_en = 1'b1;
    do_cycle();
    i_wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp, input logic exp_hit);
    i_addr = a; i_rd_en = 1'b1;
    #1;
    check({tag, "_rd"}, {32'd0, o_rdata}, {32'd0, exp});
    check({tag, "_hit"}, {63'd0, o_hit}, {63'd0, exp_hit});
    i_rd_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
    rd_chk(tag, BASE + {27'd0, off, 2'b00}, exp, 1'b1);
  endtask

  function automatic logic [31:0] gen_data(input logic [2:0] off);
    logic [31:0] d;
    d = $urandom;
    case (off)
      3'd0, 3'd2: d = $urandom_range(0, 80);
      3'd1, 3'd3: if ($urandom_range(0, 7) != 0) d = 32'd0;
      3'd4: if ($urandom_range(0, 1) == 1) d[1:0] = 2'b11;
      3'd5: d = {($urandom_range(0, 3) == 0) ? d[31:16] : 16'd0, 16'($urandom_range(0, 3))};
      3'd6: d = $urandom_range(0, 30);
      default: if ($urandom_range(0, 3) != 0) d = 32'd0;
    endcase
    return d;
  endfunction

  initial begin
    logic [2:0]  off;
    logic [31:0] a;
    int          pulses;
    i_rst = 1'b1; i_addr = BASE; i_wdata = 32'd0; i_wr_en = 1'b0; i_rd_en = 1'b0;
    m_mtime = 64'd0; m_cmp = '1; m_reload = 64'd0; m_en = 1'b0; m_ie = 1'b0;
    m_irq = 1'b0; m_presc = 16'd0; m_pc = 0;

    // T1 reset
    do_cycle(); do_cycle();
    i_rst = 1'b0;
    rd("t1_mtime_lo", 3'd0, 32'd0);
    rd("t1_cmp_hi", 3'd3, 32'hFFFF_FFFF);
    rd("t1_ctrl", 3'd4, 32'd0);
    check("t1_irq", {63'd0, o_tm_interupt}, 64'd0);

    // T2 prescaled count then full rate
    wr(3'd5, 32'd3);
    wr(3'd4, 32'd1);
    repeat (40) do_cycle();
    rd("t2_lo_presc3", 3'd0, 32'd10);
    wr(3'd5, 32'd0);
    repeat (5) do_cycle();
    rd("t2_lo_presc0", 3'd0, 32'd15);

    // T3 interrupt assert/deassert
    wr(3'd4, 32'd0);
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd2, 32'd20);
    wr(3'd3, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd3);
    for (int k = 1; k <= 25; k++) begin
      do_cycle();
      check("t3_mtime", {32'd0, m_read(3'd0)}, 64'(k));
      check("t3_irq_lvl", {63'd0, o_tm_interupt}, {63'd0, k >= 21});
    end
    rd("t3_mtime_25", 3'd0, 32'd25);
    wr(3'd2, 32'd100);
    check("t3_irq_hold", {63'd0, o_tm_interupt}, 64'd1);
    do_cycle();
    check("t3_irq_fall", {63'd0, o_tm_interupt}, 64'd0);

    // T4 carry and wrap
    wr(3'd4, 32'd0);
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd4, 32'd1);
    do_cycle();
    rd("t4_carry_hi", 3'd1, 32'd1);
    rd("t4_carry_lo", 3'd0, 32'd0);
    wr(3'd4, 32'd0);
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd4, 32'd1);
    do_cycle();
    rd("t4_wrap_lo", 3'd0, 32'd0);
    rd("t4_wrap_hi", 3'd1, 32'd0);
    repeat (3) begin
      do_cycle();
      check("t4_no_irq", {63'd0, o_tm_interupt}, 64'd0);
    end

    // T5 write/tick collision and window decode
    wr(3'd0, 32'd5);
    rd("t5_coll_lo", 3'd0, 32'd5);
    rd("t5_coll_hi", 3'd1, 32'd0);
    i_addr = 32'h0000_3000; i_wdata = 32'h0000_DEAD; i_wr_en = 1'b1;
    do_cycle();
    i_wr_en = 1'b0;
    rd("t5_oow_wr", 3'd0, 32'd6);
    wr(3'd1, 32'd2);
    rd("t5_coll_hi_lo", 3'd0, 32'd6);
    rd("t5_coll_hi_hi", 3'd1, 32'd2);
    rd_chk("t5_oow_above", 32'h0000_3000, 32'd0, 1'b0);
    rd_chk("t5_oow_below", 32'h0000_1FFC, 32'd0, 1'b0);
    i_addr = BASE; i_rd_en = 1'b0;
    #1;
    check("t5_no_rden", {32'd0, o_rdata}, 64'd0);
    wr(3'd6, 32'h0000_1234);
    rd("t5_off6", 3'd6, m_read(3'd6));

`ifdef MTIMER_AUTO_RELOAD_EN
    // T6 periodic reload
    wr(3'd4, 32'd0);
    wr(3'd5, 32'd0);
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd2, 32'd10);
    wr(3'd3, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd0);
    wr(3'd6, 32'd10);
    wr(3'd7, 32'd0);
    wr(3'd4, 32'd3);
    pulses = 0;
    for (int k = 1; k <= 35; k++) begin
      do_cycle();
      if (o_tm_interupt) pulses++;
      check("t6_pulse", {63'd0, o_tm_interupt}, {63'd0, (k == 11 || k == 21 || k == 31)});
    end
    check("t6_pulse_cnt", 64'(pulses), 64'd3);
    rd("t6_cmp_lo", 3'd2, 32'd40);
`endif

    // Randomized traffic, including mid-run resets
    i_rst = 1'b1; do_cycle(); i_rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      off = 3'($urandom_range(0, 7));
      if (r < 2) begin
        i_rst = 1'b1; do_cycle(); i_rst = 1'b0;
      end else if (r < 35) begin
        a = BASE + {27'd0, off, 2'b00} + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) a = a + 32'h0000_0020;
        i_addr = a; i_wdata = gen_data(off); i_wr_en = 1'b1;
        do_cycle();
        i_wr_en = 1'b0;
      end else begin
        if ($urandom_range(0, 9) == 0)
          rd_chk("rnd_oow", BASE - 32'd4 - {27'd0, off, 2'b00}, 32'd0, 1'b0);
        else
          rd("rnd_rd", off, m_read(off));
        do_cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
